aurora_err_counter: RTL
=======================

Name: aurora_err_counter

Overview:
- Per-lane link checker that sits upstream of the SRIO status readback block and produces one `aurora_err_countX4_N` word per Aurora x4 lane.
- Monitors the Aurora RX user stream, which carries an incrementing test pattern from the far-end generator, and compares every valid beat against the expected value.
- Maintains a saturating 32-bit word-error count, pattern-lock status and a resync counter.
- The SRIO readback side reads the counts; software clears them via a pulse.

Parameters:
- DATA_WIDTH, 64, width of rx_tdata and of the incrementing pattern.
- LOSS_THRESH, 8, consecutive mismatched beats in LOCKED that force return to HUNT (range 2..255).
- CNT_W, 32, width of err_count.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- channel_up  input  1  Aurora channel-up, level.
- rx_tvalid  input  1  RX beat valid.
- rx_tdata  input  DATA_WIDTH  RX beat data.
- err_clr  input  1  single-cycle pulse that clears err_count and resync_count.
- err_count  output  CNT_W  saturating mismatched-beat count; feeds aurora_err_countX4_N.
- resync_count  output  16  number of LOCKED->HUNT transitions, saturating.
- lock  output  1  high while the FSM is in LOCKED.
- beat_err  output  1  one-cycle pulse per mismatched beat counted.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, expected=0, miss_run=0.
- FSM states: IDLE, HUNT, LOCKED.
- IDLE:
  - Entered from any state the cycle after channel_up is sampled low.
  - Ignores rx_tvalid.
  - Moves to HUNT when channel_up is sampled high.
- HUNT:
  - The first rx_tvalid beat seeds expected = rx_tdata+1 (mod 2^DATA_WIDTH).
  - Next state is LOCKED; no error is counted on the seed beat.
- LOCKED:
  - Each rx_tvalid beat is compared with expected.
  - Match: expected <= expected+1, miss_run <= 0.
  - Mismatch:
    - err_count increments and beat_err pulses.
    - Reseed expected <= rx_tdata+1.
    - miss_run increments.
    - If miss_run reaches LOSS_THRESH, go to HUNT, increment resync_count, clear miss_run.
- Cycles with rx_tvalid=0 leave all state unchanged; gaps are legal.
- Latency: err_count, beat_err and lock update on the clock edge that samples the beat, i.e. visible one cycle after the beat.
- Pattern wrap: expected 2^DATA_WIDTH-1 followed by 0 is a match.
- Saturation:
  - err_count holds at 2^CNT_W-1.
  - resync_count holds at 16'hFFFF.
  - beat_err still pulses while err_count is saturated.
- err_clr:
  - Synchronous. err_count <= 0 and resync_count <= 0 on the next edge.
  - If a mismatch occurs in the same cycle, the clear wins: count becomes 0, not 1. beat_err still pulses.
  - Does not affect FSM, expected or lock.
- channel_up drop mid-stream:
  - Counters are retained.
  - lock <= 0 on the next edge.
  - A beat in that cycle is ignored.
  - resync_count is not incremented; only threshold loss counts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package aurora_chk_pkg holds:
  - FSM state encoding (IDLE=2'd0, HUNT=2'd1, LOCKED=2'd2).
  - Default DATA_WIDTH, CNT_W and LOSS_THRESH constants, so the aurora_top instantiations and the status register map agree.
- One natural sub-module: sat_counter, a parameterised width, increment/clear/saturate counter. It is used for err_count and resync_count.
- The top instantiates one aurora_err_counter per x4 lane.

Test Plan:
- Reset then channel_up=1, send beats 0x10..0x1F contiguous -> lock=1 one cycle after beat 0x10, err_count=0, beat_err never pulses.
- In LOCKED, send 5,6,99,100,101 -> exactly one beat_err, err_count=1, lock stays 1 (reseed at 99).
- LOSS_THRESH=8, send 8 consecutive non-sequential beats (e.g. 3,3,3...) -> err_count=8, resync_count=1, lock=0 after the 8th; the next beat reseeds and lock returns to 1.
- Pattern wrap with DATA_WIDTH=64: beats FFFF_FFFF_FFFF_FFFE, FFFF_FFFF_FFFF_FFFF, 0, 1 -> no errors.
- Preload err_count near 0xFFFF_FFFE via forced mismatches, inject 3 more -> err_count holds 0xFFFF_FFFF and beat_err pulses 3 times. Then assert err_clr coincident with a mismatch -> err_count=0.
- Drop channel_up mid-stream with err_count=4 -> lock=0 next cycle, err_count stays 4, resync_count unchanged. Raising channel_up re-enters HUNT. Assert sys_rst_n low asynchronously mid-beat -> all outputs 0 immediately.

Source files
------------

// File: rtl/aurora_chk_pkg.sv
// Shared definitions for the Aurora lane pattern checker: FSM encoding and the
// default widths/threshold that the lane instances and the status map agree on.
package aurora_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_LOSS_THRESH = 8;
  localparam int RESYNC_W        = 16;
  localparam int MISS_RUN_W      = 8;  // holds LOSS_THRESH up to 255

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over the
// increment; the count sticks at all-ones until cleared.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/aurora_err_counter.sv
// Per-lane checker for the incrementing test pattern on the Aurora RX stream:
// tracks pattern lock, counts mismatched beats and counts threshold resyncs.
module aurora_err_counter
  import aurora_chk_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  channel_up,
  input  logic                  rx_tvalid,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      err_count,
  output logic [RESYNC_W-1:0]   resync_count,
  output logic                  lock,
  output logic                  beat_err
);

  chk_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   expected_q, expected_d;
  logic [MISS_RUN_W-1:0]   miss_run_q, miss_run_d;
  logic                    lock_q, beat_err_q;
  logic                    mismatch, resync;
  logic [DATA_WIDTH-1:0]   seed;

  assign seed = rx_tdata + DATA_WIDTH'(1);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case/if tree leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    miss_run_d = miss_run_q;
    mismatch   = 1'b0;
    resync     = 1'b0;

    if (!channel_up) begin
      // Link down: drop to IDLE and ignore any beat presented this cycle.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: begin
          if (rx_tvalid) begin
            expected_d = seed;
            miss_run_d = '0;
            state_d    = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (rx_tvalid) begin
            if (rx_tdata == expected_q) begin
              expected_d = expected_q + DATA_WIDTH'(1);
              miss_run_d = '0;
            end else begin
              mismatch   = 1'b1;
              expected_d = seed;
              if (miss_run_q + MISS_RUN_W'(1) == MISS_RUN_W'(LOSS_THRESH)) begin
                miss_run_d = '0;
                resync     = 1'b1;
                state_d    = ST_HUNT;
              end else begin
                miss_run_d = miss_run_q + MISS_RUN_W'(1);
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      expected_q <= '0;
      miss_run_q <= '0;
      lock_q     <= 1'b0;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      miss_run_q <= miss_run_d;
      lock_q     <= (state_d == ST_LOCKED);
      beat_err_q <= mismatch;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr_i   (err_clr),
    .inc_i   (mismatch),
    .count_o (err_count)
  );

  sat_counter #(.W(RESYNC_W)) u_resync_cnt (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr_i   (err_clr),
    .inc_i   (resync),
    .count_o (resync_count)
  );

  assign lock     = lock_q;
  assign beat_err = beat_err_q;

endmodule
